// File: rtl/mjpeg_zz_rle_core.sv
// mjpeg_zz_rle_core: reads one 8x8 block of quantized coefficients in zigzag
// order through memory port 0 and writes JPEG (run, size, amplitude) symbol
// words through memory port 1, then pulses done for the register block.
module mjpeg_zz_rle_core #(
    parameter int MAX_COEF  = 64,
    parameter int IN_STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  num_coef,
    output logic        in_valid,
    input  logic        in_ready,
    output logic [15:0] in_addr,
    input  logic [31:0] in_rdata,
    output logic        out_valid,
    output logic        out_write,
    input  logic        out_ready,
    output logic [15:0] out_addr,
    output logic [31:0] out_wdata,
    output logic        done,
    output logic [6:0]  sym_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EVAL = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Where the FSM goes once the pending symbol write is accepted
    typedef enum logic [1:0] {
        AFT_NEXT = 2'd0,   // coefficient finished: fetch next or finish
        AFT_EVAL = 2'd1,   // ZRL emitted: re-evaluate the same coefficient
        AFT_DONE = 2'd2    // EOB emitted: block complete
    } after_t;

    localparam logic [31:0] SYM_ZRL = 32'hF000_0000;
    localparam logic [31:0] SYM_EOB = 32'h0000_0000;

    // Natural (row-major) index for each zigzag position
    localparam logic [5:0] ZZ_TAB [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Bit length of a non-negative magnitude (0..15)
    function automatic logic [3:0] bit_len(input logic [15:0] mag);
        logic [3:0] len;
        len = 4'd0;
        for (int i = 0; i < 15; i++) begin
            len = mag[i] ? 4'(i + 1) : len;
        end
        return len;
    endfunction

    // Pack one symbol word: run, size, DC flag and amplitude
    function automatic logic [31:0] make_sym(input logic [3:0] run, input logic [3:0] size,
                                             input logic dc, input logic [15:0] amp);
        return {run, size, 7'd0, dc, amp};
    endfunction

    state_t      state_q, state_d;
    after_t      after_q, after_d;
    logic        start_q;
    logic [6:0]  n_q, n_d;
    logic [6:0]  k_q, k_d;
    logic [5:0]  run_q, run_d;
    logic [15:0] coef_q, coef_d;
    logic [15:0] out_addr_q, out_addr_d;
    logic [6:0]  sym_count_q, sym_count_d;
    logic [31:0] wdata_d;

    logic        in_valid_q, in_valid_d;
    logic [15:0] in_addr_q, in_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_wdata_q, out_wdata_d;
    logic        done_q, done_d;

    logic [15:0] sat_s, mag_s, amp_s;
    logic [3:0]  size_s;
    logic        unused_rdata_s;

    assign unused_rdata_s = ^in_rdata[31:16];

    // Saturate the held coefficient and derive its size and amplitude fields
    always_comb begin
        sat_s  = (coef_q == 16'h8000) ? 16'h8001 : coef_q;
        mag_s  = sat_s[15] ? (16'd0 - sat_s) : sat_s;
        size_s = bit_len(mag_s);
        if (sat_s[15]) begin
            amp_s = (sat_s - 16'd1) & ((16'd1 << size_s) - 16'd1);
        end else begin
            amp_s = sat_s;
        end
    end

    // State, datapath and output registers; reset abandons any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            after_q     <= AFT_NEXT;
            start_q     <= 1'b0;
            n_q         <= 7'd0;
            k_q         <= 7'd0;
            run_q       <= 6'd0;
            coef_q      <= 16'd0;
            out_addr_q  <= 16'd0;
            sym_count_q <= 7'd0;
            in_valid_q  <= 1'b0;
            in_addr_q   <= 16'd0;
            out_valid_q <= 1'b0;
            out_wdata_q <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            after_q     <= after_d;
            start_q     <= start;
            n_q         <= n_d;
            k_q         <= k_d;
            run_q       <= run_d;
            coef_q      <= coef_d;
            out_addr_q  <= out_addr_d;
            sym_count_q <= sym_count_d;
            in_valid_q  <= in_valid_d;
            in_addr_q   <= in_addr_d;
            out_valid_q <= out_valid_d;
            out_wdata_q <= out_wdata_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath update: fetch, evaluate, emit symbols
    always_comb begin
        state_d     = state_q;
        after_d     = after_q;
        n_d         = n_q;
        k_d         = k_q;
        run_d       = run_q;
        coef_d      = coef_q;
        out_addr_d  = out_addr_q;
        sym_count_d = sym_count_q;
        wdata_d     = out_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    n_d         = (num_coef > 7'(MAX_COEF)) ? 7'(MAX_COEF) : num_coef;
                    k_d         = 7'd0;
                    run_d       = 6'd0;
                    out_addr_d  = 16'd0;
                    sym_count_d = 7'd0;
                    state_d     = (num_coef == 7'd0) ? S_DONE : S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (in_ready) begin
                    coef_d  = in_rdata[15:0];
                    state_d = S_EVAL;
                end else begin
                    state_d = S_RD;
                end
            end
            S_EVAL: begin
                if (k_q == 7'd0) begin
                    wdata_d = make_sym(4'd0, size_s, 1'b1, amp_s);
                    after_d = AFT_NEXT;
                    state_d = S_WR;
                end else if (sat_s == 16'd0) begin
                    run_d = run_q + 6'd1;
                    if (k_q == n_q - 7'd1) begin
                        wdata_d = SYM_EOB;
                        after_d = AFT_DONE;
                        state_d = S_WR;
                    end else begin
                        k_d     = k_q + 7'd1;
                        state_d = S_RD;
                    end
                end else if (run_q >= 6'd16) begin
                    wdata_d = SYM_ZRL;
                    run_d   = run_q - 6'd16;
                    after_d = AFT_EVAL;
                    state_d = S_WR;
                end else begin
                    wdata_d = make_sym(run_q[3:0], size_s, 1'b0, amp_s);
                    run_d   = 6'd0;
                    after_d = AFT_NEXT;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (out_ready) begin
                    out_addr_d  = out_addr_q + 16'd1;
                    sym_count_d = sym_count_q + 7'd1;
                    case (after_q)
                        AFT_EVAL: state_d = S_EVAL;
                        AFT_DONE: state_d = S_DONE;
                        default: begin
                            if (k_q == n_q - 7'd1) begin
                                state_d = S_DONE;
                            end else begin
                                k_d     = k_q + 7'd1;
                                state_d = S_RD;
                            end
                        end
                    endcase
                end else begin
                    state_d = S_WR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every port comes straight off a flop
    always_comb begin
        in_valid_d  = (state_d == S_RD);
        out_valid_d = (state_d == S_WR);
        done_d      = (state_d == S_DONE);
        if (state_d == S_RD) begin
            in_addr_d = {10'd0, ZZ_TAB[k_d[5:0]]} * 16'(IN_STRIDE);
        end else begin
            in_addr_d = 16'd0;
        end
        if (state_d == S_WR) begin
            out_wdata_d = wdata_d;
        end else begin
            out_wdata_d = 32'd0;
        end
    end

    assign in_valid  = in_valid_q;
    assign in_addr   = in_addr_q;
    assign out_valid = out_valid_q;
    assign out_write = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_wdata = out_wdata_q;
    assign done      = done_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_mjpeg_zz_rle_core.sv
// Self-checking bench for mjpeg_zz_rle_core: a memory model answers reads,
// expected read addresses and symbol words are queued when a block is set up
// and popped as the core issues requests.
module tb_mjpeg_zz_rle_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  num_coef;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_addr;
    logic [31:0] in_rdata;
    logic        out_valid;
    logic        out_write;
    logic        out_ready;
    logic [15:0] out_addr;
    logic [31:0] out_wdata;
    logic        done;
    logic [6:0]  sym_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [64];
    int          zig [64];
    logic [15:0] exp_addr_q [$];
    logic [31:0] exp_word_q [$];
    int          rd_count;
    int          wr_count;
    int          done_cycles;

    always #5 clk = ~clk;

    mjpeg_zz_rle_core #(.MAX_COEF(64), .IN_STRIDE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_coef  (num_coef),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_rdata  (in_rdata),
        .out_valid (out_valid),
        .out_write (out_write),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_wdata (out_wdata),
        .done      (done),
        .sym_count (sym_count)
    );

    // Zigzag order generated by walking anti-diagonals, alternating direction
    task automatic build_zig();
        int idx;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zig[idx] = r * 8 + (s - r);
                    idx++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zig[idx] = r * 8 + (s - r);
                    idx++;
                end
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    endtask

    task automatic push_addrs(input int n);
        int m;
        m = (n > 64) ? 64 : n;
        for (int k = 0; k < m; k++) exp_addr_q.push_back(16'(zig[k] * 4));
    endtask

    // Reference JPEG run-length coder over the bench memory
    task automatic model_words(input int n);
        int run;
        int v;
        int mag;
        int size;
        int amp;
        run = 0;
        for (int k = 0; k < n; k++) begin
            v = int'($signed(mem[zig[k]]));
            if (v == -32768) v = -32767;
            mag  = (v < 0) ? -v : v;
            size = $clog2(mag + 1);
            amp  = (v > 0) ? v : ((v < 0) ? ((v - 1) & ((1 << size) - 1)) : 0);
            if (k == 0) begin
                exp_word_q.push_back(32'((size << 24) | (1 << 16) | amp));
            end else if (v == 0) begin
                run++;
            end else begin
                while (run > 15) begin
                    exp_word_q.push_back(32'hF000_0000);
                    run -= 16;
                end
                exp_word_q.push_back(32'((run << 28) | (size << 24) | amp));
                run = 0;
            end
        end
        if (run > 0) exp_word_q.push_back(32'h0000_0000);
    endtask

    task automatic launch(input int n);
        @(negedge clk);
        num_coef = 7'(n);
        start    = 1'b1;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Serve reads/writes until done, comparing against the queues every cycle
    task automatic run_block(input bit stall, input int budget);
        bit          fin;
        bit          in_wait;
        bit          out_wait;
        logic [15:0] hold_in_addr;
        logic [15:0] hold_out_addr;
        logic [31:0] hold_wdata;
        logic [15:0] ea;
        logic [31:0] ew;
        int          cyc;
        fin = 1'b0; in_wait = 1'b0; out_wait = 1'b0; cyc = 0;
        hold_in_addr = 16'd0; hold_out_addr = 16'd0; hold_wdata = 32'd0;
        rd_count = 0; wr_count = 0; done_cycles = 0;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (in_wait) begin
                checks++;
                if (in_valid !== 1'b1 || in_addr !== hold_in_addr) begin
                    errors++;
                    $display("FAIL in_hold: in_valid=%b in_addr=%h, required 1 / %h", in_valid, in_addr, hold_in_addr);
                end
            end
            if (out_wait) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== hold_out_addr || out_wdata !== hold_wdata) begin
                    errors++;
                    $display("FAIL out_hold: valid=%b addr=%h data=%h, required 1 / %h / %h",
                             out_valid, out_addr, out_wdata, hold_out_addr, hold_wdata);
                end
            end
            checks++;
            if ((in_valid === 1'b1 && out_valid === 1'b1) || out_write !== out_valid) begin
                errors++;
                $display("FAIL port_excl: in_valid=%b out_valid=%b out_write=%b, required exclusive and write==valid",
                         in_valid, out_valid, out_write);
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                done_cycles = cyc;
            end
            in_ready  = in_valid && (!stall || ($urandom_range(0, 2) != 0));
            in_rdata  = {16'($urandom), mem[in_addr[7:2]]};
            out_ready = out_valid && (!stall || ($urandom_range(0, 2) != 0));
            if (in_valid && in_ready) begin
                rd_count++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read: in_addr=%h, required no read", in_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (in_addr !== ea) begin
                        errors++;
                        $display("FAIL in_addr: got %h, required %h (read %0d)", in_addr, ea, rd_count - 1);
                    end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_word_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write: data=%h, required no write", out_wdata);
                end else begin
                    ew = exp_word_q.pop_front();
                    if (out_wdata !== ew || out_addr !== 16'(wr_count)) begin
                        errors++;
                        $display("FAIL sym_word: got [%h]=%h, required [%h]=%h",
                                 out_addr, out_wdata, 16'(wr_count), ew);
                    end
                end
                wr_count++;
            end
            in_wait       = in_valid && !in_ready;
            out_wait      = out_valid && !out_ready;
            hold_in_addr  = in_addr;
            hold_out_addr = out_addr;
            hold_wdata    = out_wdata;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", budget);
        end
        @(negedge clk);
        in_ready  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_word_q.size() != 0) begin
            errors++;
            $display("FAIL missing_traffic: %0d reads and %0d writes left, required 0 and 0",
                     exp_addr_q.size(), exp_word_q.size());
        end
        exp_addr_q.delete();
        exp_word_q.delete();
        checks++;
        if (sym_count !== 7'(wr_count)) begin
            errors++;
            $display("FAIL sym_count: got %0d, required %0d", sym_count, wr_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_valid !== 1'b0 || in_addr !== 16'd0 || out_valid !== 1'b0 || out_write !== 1'b0 ||
            out_addr !== 16'd0 || out_wdata !== 32'd0 || done !== 1'b0 || sym_count !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: iv=%b ia=%h ov=%b ow=%b oa=%h od=%h dn=%b sc=%0d, required all 0",
                     in_valid, in_addr, out_valid, out_write, out_addr, out_wdata, done, sym_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dc_only();
        clear_mem();
        mem[0] = 16'd5;
        push_addrs(64);
        exp_word_q.push_back(32'h0301_0005);
        exp_word_q.push_back(32'h0000_0000);
        launch(64);
        run_block(1'b0, 2000);
        release_start();
        checks++;
        if (rd_count != 64) begin
            errors++;
            $display("FAIL dc_reads: got %0d reads, required 64", rd_count);
        end
    endtask

    task automatic test_neg_ac();
        clear_mem();
        mem[1] = 16'hFFFD;
        push_addrs(64);
        exp_word_q.push_back(32'h0001_0000);
        exp_word_q.push_back(32'h0200_0000);
        exp_word_q.push_back(32'h0000_0000);
        launch(64);
        run_block(1'b0, 2000);
        release_start();
    endtask

    task automatic test_zrl(input bit stall);
        clear_mem();
        mem[40] = 16'd1;
        push_addrs(64);
        exp_word_q.push_back(32'h0001_0000);
        exp_word_q.push_back(32'hF000_0000);
        exp_word_q.push_back(32'h3100_0001);
        exp_word_q.push_back(32'h0000_0000);
        launch(64);
        run_block(stall, 3000);
        release_start();
    endtask

    task automatic test_last_coef();
        clear_mem();
        mem[63] = 16'd7;
        push_addrs(64);
        exp_word_q.push_back(32'h0001_0000);
        repeat (3) exp_word_q.push_back(32'hF000_0000);
        exp_word_q.push_back(32'hE300_0007);
        launch(64);
        run_block(1'b0, 2000);
        release_start();
    endtask

    task automatic test_num_zero();
        clear_mem();
        launch(0);
        run_block(1'b0, 20);
        release_start();
        checks++;
        if (done_cycles > 3 || rd_count != 0 || wr_count != 0) begin
            errors++;
            $display("FAIL num_zero: done after %0d cycles with %0d reads %0d writes, required <=3 / 0 / 0",
                     done_cycles, rd_count, wr_count);
        end
    endtask

    task automatic test_num_clamp();
        clear_mem();
        mem[0] = 16'd5;
        push_addrs(100);
        exp_word_q.push_back(32'h0301_0005);
        exp_word_q.push_back(32'h0000_0000);
        launch(100);
        run_block(1'b0, 2000);
        release_start();
        checks++;
        if (rd_count != 64) begin
            errors++;
            $display("FAIL clamp_reads: got %0d reads, required 64", rd_count);
        end
    endtask

    // Single-coefficient block with the most negative value; start stays high after
    task automatic test_sat_hold_start();
        int seen;
        clear_mem();
        mem[0] = 16'h8000;
        push_addrs(1);
        exp_word_q.push_back(32'h0F01_0000);
        launch(1);
        run_block(1'b0, 200);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_valid !== 1'b0 || done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL hold_start: %0d active cycles with start held, required 0", seen);
        end
        release_start();
    endtask

    task automatic test_reset_mid_rd();
        int seen;
        clear_mem();
        in_ready = 1'b0;
        launch(64);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd_entry: in_valid=%b, required 1", in_valid);
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_valid !== 1'b0 || in_addr !== 16'd0 || out_valid !== 1'b0 || out_write !== 1'b0 ||
            out_addr !== 16'd0 || out_wdata !== 32'd0 || done !== 1'b0 || sym_count !== 7'd0) begin
            errors++;
            $display("FAIL mid_rd_reset: iv=%b ia=%h ov=%b dn=%b sc=%0d, required all 0",
                     in_valid, in_addr, out_valid, done, sym_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || in_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_rd_after: %0d cycles with done/in_valid, required 0", seen);
        end
    endtask

    task automatic test_random_blocks();
        int n;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 15) == 0)     mem[i] = 16'h8000;
                else if ($urandom_range(0, 4) == 0) mem[i] = 16'($urandom);
                else if ($urandom_range(0, 4) == 0) mem[i] = 16'($signed(8'($urandom)));
                else                                mem[i] = 16'd0;
            end
            n = (t == 0) ? 64 : int'($urandom_range(1, 64));
            push_addrs(n);
            model_words(n);
            launch(n);
            run_block(1'b1, 3000);
            release_start();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_coef  = 7'd0;
        in_ready  = 1'b0;
        in_rdata  = 32'd0;
        out_ready = 1'b0;
        build_zig();
        test_reset();
        test_dc_only();
        test_neg_ac();
        test_zrl(1'b0);
        test_last_coef();
        test_zrl(1'b1);
        test_num_zero();
        test_num_clamp();
        test_sat_hold_start();
        test_reset_mid_rd();
        test_random_blocks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
